// File: rtl/fifo_pkt_writer.sv
// rtl/fifo_pkt_writer.sv - write-side packet framer for the async FIFO (clk_w domain)
// Frames each upstream packet as header, data words, length word, checksum word.
module fifo_pkt_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int CNT_W      = 8,
  parameter int MARGIN     = 2
) (
  input  logic                  clk_w,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [CNT_W-1:0]      fifo_level,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  pkt_done,
  output logic [15:0]           pkt_count,
  output logic                  busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DATA    = 2'd1;
  localparam logic [1:0] TRL_LEN = 2'd2;
  localparam logic [1:0] TRL_SUM = 2'd3;

  localparam int THRESH = DEPTH - 1 - MARGIN;

  logic [1:0]            state;
  logic [7:0]            seq;
  logic [15:0]           len;
  logic [DATA_WIDTH-1:0] csum;
  logic                  wr_ok;
  logic                  accept;

  // MARGIN words of headroom cover the latency of the occupancy count.
  assign wr_ok   = ({{(32-CNT_W){1'b0}}, fifo_level} < 32'(THRESH));
  assign s_ready = (state == DATA) && wr_ok;
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);

  function automatic logic [DATA_WIDTH-1:0] word32(input logic [31:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    r[31:0] = w;
    return r;
  endfunction

  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      pkt_done  <= 1'b0;
      pkt_count <= 16'h0000;
      seq       <= 8'h00;
      len       <= 16'h0000;
      csum      <= '0;
    end else begin
      wr_en    <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en && s_valid && wr_ok) begin
            wr_en   <= 1'b1;
            wr_data <= word32({8'hA5, seq, 16'h0000});
            len     <= 16'h0000;
            csum    <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_data <= s_data;
            len     <= (len == 16'hFFFF) ? len : len + 16'd1;
            csum    <= csum ^ s_data;
            if (s_last) state <= TRL_LEN;
          end
        end
        TRL_LEN: begin
          if (wr_ok) begin
            wr_en   <= 1'b1;
            wr_data <= word32({8'h5A, 8'h00, len});
            state   <= TRL_SUM;
          end
        end
        TRL_SUM: begin
          if (wr_ok) begin
            wr_en     <= 1'b1;
            wr_data   <= csum;
            pkt_done  <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
            seq       <= seq + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb/tb_fifo_pkt_writer.sv - self-checking bench for fifo_pkt_writer
// Expected FIFO writes are queued as packets are driven and popped on each wr_en.
module tb_fifo_pkt_writer;

  logic        clk_w = 1'b0;
  logic        rst;
  logic        en;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  fifo_level;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        pkt_done;
  logic [15:0] pkt_count;
  logic        busy;

  always #5 clk_w = ~clk_w;

  fifo_pkt_writer #(.DATA_WIDTH(32), .DEPTH(128), .CNT_W(8), .MARGIN(2)) dut (
    .clk_w(clk_w), .rst(rst), .en(en), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .fifo_level(fifo_level), .wr_en(wr_en),
    .wr_data(wr_data), .pkt_done(pkt_done), .pkt_count(pkt_count), .busy(busy)
  );

  typedef struct {
    int               n;
    logic [3:0][31:0] d;
    logic [15:0]      len;
    logic [31:0]      csum;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t       q[$];
  vec_t       vecs[4];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] seq_m = 8'h00;
  int         cnt_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic push_exp(input logic [31:0] data, input logic done);
    exp_t e;
    e.data = data;
    e.done = done;
    q.push_back(e);
  endtask

  task automatic push_pkt(input vec_t v);
    push_exp({8'hA5, seq_m, 16'h0000}, 1'b0);
    for (int i = 0; i < v.n; i++) push_exp(v.d[i], 1'b0);
    push_exp({8'h5A, 8'h00, v.len}, 1'b0);
    push_exp(v.csum, 1'b1);
    seq_m = seq_m + 8'd1;
    cnt_m++;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    s_last  = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_w);
      acc = s_ready;
      @(posedge clk_w);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no s_ready expected accept of 0x%08h", w);
    end
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk_w);
      #1;
      ok = !busy && (q.size() == 0);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d expected 0 0", busy, q.size());
    end
  endtask

  task automatic run_pkt(input vec_t v);
    push_pkt(v);
    for (int i = 0; i < v.n; i++) send_word(v.d[i], (i == v.n - 1));
    wait_idle();
    chk("pkt_count", {16'h0, pkt_count}, 32'(cnt_m));
  endtask

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk_w) begin
    exp_t e;
    if (wr_en) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got 0x%08h expected no write", wr_data);
      end else begin
        e = q.pop_front();
        chk("wr_data", wr_data, e.data);
        chk1("pkt_done", pkt_done, e.done);
      end
    end else if (pkt_done) begin
      checks++;
      failures++;
      $display("FAIL pkt_done_no_write: got pkt_done=1 expected 0");
    end
  end

  initial begin
    vec_t vt;
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_level = '0;
    vecs[0] = '{3, {32'h0, 32'h33333333, 32'h22222222, 32'h11111111}, 16'd3, 32'h00000000};
    vecs[1] = '{1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 16'd1, 32'hDEADBEEF};
    vecs[2] = '{2, {32'h0, 32'h0, 32'hFFFF0000, 32'h0000FFFF}, 16'd2, 32'hFFFFFFFF};
    vecs[3] = '{4, {32'h8, 32'h4, 32'h2, 32'h1}, 16'd4, 32'h0000000F};

    repeat (2) @(posedge clk_w);
    #1;
    chk1("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk1("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_pkt_count", {16'h0, pkt_count}, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b0);
    rst = 1'b0;
    en = 1'b1;
    @(posedge clk_w);
    #1;

    for (int i = 0; i < 4; i++) run_pkt(vecs[i]);

    // Occupancy at threshold for 5 cycles in the middle of a packet.
    vt = '{3, {32'h0, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 16'd3, 32'hDDDD0000};
    push_pkt(vt);
    send_word(vt.d[0], 1'b0);
    fifo_level = 8'd125;
    s_valid = 1'b1; s_data = vt.d[1]; s_last = 1'b0;
    repeat (5) begin
      @(negedge clk_w);
      chk1("hold_s_ready", s_ready, 1'b0);
      @(posedge clk_w);
      #1;
      chk1("hold_wr_en", wr_en, 1'b0);
    end
    fifo_level = 8'd0;
    send_word(vt.d[1], 1'b0);
    send_word(vt.d[2], 1'b1);
    wait_idle();
    chk("hold_pkt_count", {16'h0, pkt_count}, 32'(cnt_m));

    en = 1'b0;
    s_valid = 1'b1; s_data = 32'h12345678; s_last = 1'b1;
    repeat (6) begin
      @(posedge clk_w);
      #1;
      chk1("en0_wr_en", wr_en, 1'b0);
      chk1("en0_busy", busy, 1'b0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    en = 1'b1;

    // en dropped after the first data word: trailers still follow.
    vt = '{3, {32'h0, 32'h04040404, 32'h02020202, 32'h01010101}, 16'd3, 32'h07070707};
    push_pkt(vt);
    send_word(vt.d[0], 1'b0);
    en = 1'b0;
    send_word(vt.d[1], 1'b0);
    send_word(vt.d[2], 1'b1);
    wait_idle();
    chk("en_drop_pkt_count", {16'h0, pkt_count}, 32'(cnt_m));
    s_valid = 1'b1; s_data = 32'h0BADF00D;
    repeat (5) begin
      @(posedge clk_w);
      #1;
      chk1("en_drop_idle_wr_en", wr_en, 1'b0);
      chk1("en_drop_idle_busy", busy, 1'b0);
    end
    s_valid = 1'b0;
    en = 1'b1;

    // Reset after two data words of a four-word packet.
    vt = '{4, {32'h0A0A0A0A, 32'h09090909, 32'h08080808, 32'h07070707}, 16'd4, 32'h0};
    push_pkt(vt);
    send_word(vt.d[0], 1'b0);
    send_word(vt.d[1], 1'b0);
    @(negedge clk_w);
    #1;
    rst = 1'b1;
    #1;
    chk1("midrst_wr_en", wr_en, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_pkt_count", {16'h0, pkt_count}, 32'h0);
    chk1("midrst_s_ready", s_ready, 1'b0);
    q.delete();
    seq_m = 8'h00;
    cnt_m = 0;
    @(posedge clk_w);
    #1;
    rst = 1'b0;
    @(posedge clk_w);
    #1;
    run_pkt(vecs[1]);

    // 256 single-word packets from reset: seq wraps 0xFF -> 0x00.
    rst = 1'b1;
    #1;
    q.delete();
    seq_m = 8'h00;
    cnt_m = 0;
    @(posedge clk_w);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      vt.n = 1;
      vt.d = '0;
      vt.d[0] = $urandom;
      vt.len = 16'd1;
      vt.csum = vt.d[0];
      run_pkt(vt);
    end
    chk("wrap_pkt_count", {16'h0, pkt_count}, 32'd256);
    push_pkt(vecs[1]);
    chk("wrap_header_seq", {24'h0, q[0].data[23:16]}, 32'h0);
    for (int i = 0; i < vecs[1].n; i++) send_word(vecs[1].d[i], (i == vecs[1].n - 1));
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
